// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operation sequencer and the 8-bit ALU:
// operand/result widths, sequencer state encoding and ALU opcode values.
// -----------------------------------------------------------------------------
package alu_pkg;

    // Operand width and the derived result width of the ALU.
    localparam int unsigned ALU_W     = 8;
    localparam int unsigned ALU_RES_W = 2 * ALU_W;

    // Sequencer state encoding.
    localparam int unsigned ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        GET_OP = 3'd0,
        GET_A  = 3'd1,
        GET_B  = 3'd2,
        EXEC   = 3'd3,
        DONE   = 3'd4
    } state_e;

    // ALU select codes, {s1, s2}.
    localparam logic [1:0] OP_ADD0 = 2'b00;
    localparam logic [1:0] OP_ADD1 = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    // True in the states that take a byte from the input stream.
    function automatic logic is_get_state(input state_e s);
        return (s == GET_OP) || (s == GET_A) || (s == GET_B);
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Collects a three-byte command (opcode, operand A, operand B) from a
// valid/ready byte stream, drives registered operands and selects into an
// external combinational ALU, captures its result after one settle cycle and
// offers it on a valid/ready result port. One command is in flight at a time.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_data    input byte stream; in_ready accepts a byte
//   alu_a/alu_b         registered operands to the ALU
//   alu_s1/alu_s2       registered select bits to the ALU
//   alu_y               combinational ALU result
//   res_valid/res_data  captured result; res_ready consumes it
//   op_err              one-cycle pulse on a rejected opcode byte
//   op_count            number of consumed results (wrapping)
// -----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned W     = ALU_W,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic             alu_s1,
    output logic             alu_s2,
    input  logic [2*W-1:0]   alu_y,
    output logic             res_valid,
    output logic [2*W-1:0]   res_data,
    input  logic             res_ready,
    output logic             op_err,
    output logic [CNT_W-1:0] op_count
);

    localparam int unsigned RES_W = 2 * W;
    localparam int unsigned OPH_W = W - 2;

    // Registered state and outputs.
    state_e           r_state;
    logic             r_in_ready;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [1:0]       r_sel;
    logic             r_res_valid;
    logic [RES_W-1:0] r_res_data;
    logic             r_op_err;
    logic [CNT_W-1:0] r_op_count;

    // Next-state values.
    state_e           w_state_n;
    logic             w_in_ready_n;
    logic [W-1:0]     w_a_n;
    logic [W-1:0]     w_b_n;
    logic [1:0]       w_sel_n;
    logic             w_res_valid_n;
    logic [RES_W-1:0] w_res_data_n;
    logic             w_op_err_n;
    logic [CNT_W-1:0] w_op_count_n;

    logic             w_accept;
    logic             w_op_ok;

    // A byte is taken only when the registered ready is high; ready is
    // only ever high in the GET_* states.
    assign w_accept = in_valid & r_in_ready;

    // Legal opcodes use only the two select bits.
    assign w_op_ok  = (in_data[W-1:2] == OPH_W'(0));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= GET_OP;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        w_state_n     = r_state;
        w_a_n         = r_a;
        w_b_n         = r_b;
        w_sel_n       = r_sel;
        w_res_valid_n = r_res_valid;
        w_res_data_n  = r_res_data;
        w_op_err_n    = 1'b0;
        w_op_count_n  = r_op_count;

        case (r_state)
            GET_OP: begin
                if (w_accept) begin
                    if (w_op_ok) begin
                        w_sel_n   = in_data[1:0];
                        w_state_n = GET_A;
                    end else begin
                        w_op_err_n = 1'b1;
                    end
                end
            end
            GET_A: begin
                if (w_accept) begin
                    w_a_n     = in_data;
                    w_state_n = GET_B;
                end
            end
            GET_B: begin
                if (w_accept) begin
                    w_b_n     = in_data;
                    w_state_n = EXEC;
                end
            end
            EXEC: begin
                // Operands have been stable for a full cycle; capture.
                w_res_data_n  = alu_y;
                w_res_valid_n = 1'b1;
                w_state_n     = DONE;
            end
            DONE: begin
                if (r_res_valid && res_ready) begin
                    w_res_valid_n = 1'b0;
                    w_op_count_n  = r_op_count + CNT_W'(1);
                    w_state_n     = GET_OP;
                end
            end
            default: begin
                w_state_n = GET_OP;
            end
        endcase

        // Ready follows the state we are about to enter, so it is low in
        // reset and rises on the first clock after release.
        w_in_ready_n = is_get_state(w_state_n);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_a         <= W'(0);
            r_b         <= W'(0);
            r_sel       <= 2'b00;
            r_res_valid <= 1'b0;
            r_res_data  <= RES_W'(0);
            r_op_err    <= 1'b0;
            r_op_count  <= CNT_W'(0);
        end else begin
            r_in_ready  <= w_in_ready_n;
            r_a         <= w_a_n;
            r_b         <= w_b_n;
            r_sel       <= w_sel_n;
            r_res_valid <= w_res_valid_n;
            r_res_data  <= w_res_data_n;
            r_op_err    <= w_op_err_n;
            r_op_count  <= w_op_count_n;
        end
    end

    assign in_ready  = r_in_ready;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_s1    = r_sel[1];
    assign alu_s2    = r_sel[0];
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign op_err    = r_op_err;
    assign op_count  = r_op_count;

endmodule
